// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter in front of a single line-wide memory: round-robin or fixed
// priority grant, registered request forwarding, write support and timeout abort.
module mem_arbiter_rr #(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 256,
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            petition,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] address,
   input  logic [NUM_CH-1:0]            we,
   input  logic [NUM_CH*LINE_WIDTH-1:0] dataWrite,
   output logic [NUM_CH-1:0]            serviceReady,
   output logic [LINE_WIDTH-1:0]        dataRead,
   output logic                         error,
   output logic                         petitionMem,
   output logic [ADDR_WIDTH-1:0]        addressMem,
   output logic                         weMem,
   output logic [LINE_WIDTH-1:0]        dataWriteMem,
   input  logic                         serviceReadyMem,
   input  logic [LINE_WIDTH-1:0]        dataReadMem
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0]   LAST_RST = CH_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0] ONE_HOT  = NUM_CH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_r, state_s;
   logic [CH_W-1:0]        grant_r, grant_s;
   logic [CH_W-1:0]        last_r, last_s;
   logic [CH_W-1:0]        winner_s;
   logic [CNT_W-1:0]       timeoutCnt_r, timeoutCnt_s;
   logic                   petitionMem_s, weMem_s, error_s;
   logic [ADDR_WIDTH-1:0]  addressMem_s;
   logic [LINE_WIDTH-1:0]  dataWriteMem_s, dataRead_s;
   logic [NUM_CH-1:0]      serviceReady_s;

   // Scan order starts just after the last served channel (or at 0 when fixed).
   function automatic logic [CH_W-1:0] pickWinner(input logic [NUM_CH-1:0] req,
                                                  input logic [CH_W-1:0]   last);
      logic [CH_W-1:0] win;
      logic            found;
      int              idx;
      win   = {CH_W{1'b0}};
      found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx   = (FIXED_PRIO != 0) ? (k - 1) : ((int'(last) + k) % NUM_CH);
         win   = (!found && req[idx]) ? CH_W'(idx) : win;
         found = found | req[idx];
      end
      return win;
   endfunction

   assign winner_s = pickWinner(petition, last_r);

   // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
   always_comb begin
      state_s        = state_r;
      grant_s        = grant_r;
      last_s         = last_r;
      timeoutCnt_s   = timeoutCnt_r;
      petitionMem_s  = petitionMem;
      addressMem_s   = addressMem;
      weMem_s        = weMem;
      dataWriteMem_s = dataWriteMem;
      dataRead_s     = dataRead;
      serviceReady_s = {NUM_CH{1'b0}};
      error_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (|petition) begin
               grant_s        = winner_s;
               addressMem_s   = address[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
               weMem_s        = we[winner_s];
               dataWriteMem_s = dataWrite[winner_s*LINE_WIDTH +: LINE_WIDTH];
               timeoutCnt_s   = {CNT_W{1'b0}};
               petitionMem_s  = 1'b1;
               state_s        = WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            // A memory answer in the final counted cycle still wins over the abort.
            if (serviceReadyMem) begin
               dataRead_s     = weMem ? dataRead : dataReadMem;
               petitionMem_s  = 1'b0;
               serviceReady_s = ONE_HOT << grant_r;
               state_s        = RESP;
            end else if (timeoutCnt_r == CNT_LAST) begin
               petitionMem_s  = 1'b0;
               serviceReady_s = ONE_HOT << grant_r;
               error_s        = 1'b1;
               state_s        = RESP;
            end else begin
               timeoutCnt_s = timeoutCnt_r + CNT_W'(1);
            end
         end
         RESP: begin
            last_s  = grant_r;
            state_s = IDLE;
         end
         default: begin
            petitionMem_s = 1'b0;
            state_s       = IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         grant_r      <= {CH_W{1'b0}};
         last_r       <= LAST_RST;
         timeoutCnt_r <= {CNT_W{1'b0}};
         petitionMem  <= 1'b0;
         addressMem   <= {ADDR_WIDTH{1'b0}};
         weMem        <= 1'b0;
         dataWriteMem <= {LINE_WIDTH{1'b0}};
         dataRead     <= {LINE_WIDTH{1'b0}};
         serviceReady <= {NUM_CH{1'b0}};
         error        <= 1'b0;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         last_r       <= last_s;
         timeoutCnt_r <= timeoutCnt_s;
         petitionMem  <= petitionMem_s;
         addressMem   <= addressMem_s;
         weMem        <= weMem_s;
         dataWriteMem <= dataWriteMem_s;
         dataRead     <= dataRead_s;
         serviceReady <= serviceReady_s;
         error        <= error_s;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin instance checked against a transaction-level
// model, plus a fixed-priority instance checked for starvation of the higher index.
module tb_mem_arbiter_rr;

   localparam int NCH = 4;
   localparam int AW  = 16;
   localparam int LW  = 256;
   localparam int TMO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [NCH-1:0]    petition, we, serviceReady;
   logic [NCH*AW-1:0] address;
   logic [NCH*LW-1:0] dataWrite;
   logic [LW-1:0]     dataRead, dataWriteMem, dataReadMem;
   logic              error, petitionMem, weMem, srm;
   logic [AW-1:0]     addressMem;

   logic [NCH-1:0]    petitionF, serviceReadyF;
   logic [LW-1:0]     dataReadF, dataWriteMemF;
   logic              errorF, petitionMemF, weMemF, srmF;
   logic [AW-1:0]     addressMemF;

   mem_arbiter_rr #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
                    .FIXED_PRIO(0), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .petition(petition), .address(address), .we(we),
      .dataWrite(dataWrite), .serviceReady(serviceReady), .dataRead(dataRead),
      .error(error), .petitionMem(petitionMem), .addressMem(addressMem), .weMem(weMem),
      .dataWriteMem(dataWriteMem), .serviceReadyMem(srm), .dataReadMem(dataReadMem));

   mem_arbiter_rr #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
                    .FIXED_PRIO(1), .TIMEOUT(TMO)) dutFixed (
      .clk(clk), .reset(reset), .petition(petitionF), .address({(NCH*AW){1'b0}}),
      .we({NCH{1'b0}}), .dataWrite({(NCH*LW){1'b0}}), .serviceReady(serviceReadyF),
      .dataRead(dataReadF), .error(errorF), .petitionMem(petitionMemF),
      .addressMem(addressMemF), .weMem(weMemF), .dataWriteMem(dataWriteMemF),
      .serviceReadyMem(srmF), .dataReadMem({LW{1'b0}}));

   int            total = 0;
   int            bad   = 0;
   int            modelLast;
   logic [LW-1:0] modelData;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] randLine();
      logic [LW-1:0] v;
      for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Requester closest after the last served one in the rotation.
   function automatic int rrPick(input logic [NCH-1:0] req, input int last);
      int best     = -1;
      int bestDist = NCH + 1;
      for (int c = 0; c < NCH; c++) begin
         if (req[c]) begin
            int d;
            d = (c - last - 1 + 2*NCH) % NCH;
            if (d < bestDist) begin
               bestDist = d;
               best     = c;
            end
         end
      end
      return best;
   endfunction

   // Called at a negedge in IDLE with a nonzero petition; returns at the negedge after RESP.
   task automatic runTxn(input int lat, output int obsCh);
      int            g, eff;
      logic          expErr, expWe;
      logic [AW-1:0] expAddr;
      logic [LW-1:0] expWd, line;
      g       = rrPick(petition, modelLast);
      expAddr = address[g*AW +: AW];
      expWe   = we[g];
      expWd   = dataWrite[g*LW +: LW];
      eff     = (lat <= TMO) ? lat : TMO;
      expErr  = (lat > TMO);
      check("idle_pmem", petitionMem, 1'b0);
      @(negedge clk);
      for (int i = 1; i <= eff; i++) begin
         check("wait_ctrl", {petitionMem, weMem, addressMem, serviceReady, error},
               {1'b1, expWe, expAddr, 4'b0000, 1'b0});
         if (i == 1) check("wait_wdata", dataWriteMem, expWd);
         petition = NCH'($urandom) | (4'b0001 << g);
         if (i == lat) begin
            line        = randLine();
            srm         = 1'b1;
            dataReadMem = line;
            if (!expWe) modelData = line;
         end
         @(negedge clk);
      end
      srm         = 1'b0;
      dataReadMem = randLine();
      check("resp_ctrl", {petitionMem, serviceReady, error}, {1'b0, 4'b0001 << g, expErr});
      check("resp_data", dataRead, modelData);
      obsCh = -1;
      for (int c = 0; c < NCH; c++) if (serviceReady[c]) obsCh = c;
      modelLast   = g;
      petition[g] = 1'b0;
      @(negedge clk);
      check("idle_after", {petitionMem, serviceReady, error}, 6'b000000);
   endtask

   initial begin
      int ch;
      int nF;
      int order [5] = '{0, 1, 2, 3, 0};
      reset = 1'b1; petition = 4'b0000; we = 4'b0000;
      address = {(NCH*AW){1'b0}}; dataWrite = {(NCH*LW){1'b0}};
      srm = 1'b0; dataReadMem = {LW{1'b0}}; petitionF = 4'b0000; srmF = 1'b0;
      modelLast = NCH - 1; modelData = {LW{1'b0}};
      repeat (3) @(negedge clk);
      check("rst_ctrl", {petitionMem, weMem, serviceReady, error}, 7'b0000000);
      check("rst_addr", addressMem, 16'h0000);
      check("rst_wdata", dataWriteMem, {LW{1'b0}});
      check("rst_rdata", dataRead, {LW{1'b0}});

      // fixed priority: channel 1 always beats channel 2, one grant every 3 cycles
      reset = 1'b0; petitionF = 4'b0110; nF = 0;
      for (int it = 0; it < 30; it++) begin
         @(negedge clk);
         if (serviceReadyF != 4'b0000) begin
            check("fixed_grant", serviceReadyF, 4'b0010);
            nF++;
         end
         srmF = petitionMemF;
      end
      check("fixed_count", nF, 32'd10);
      petitionF = 4'b0000;
      check("idle_quiet", petitionMem, 1'b0);

      // round-robin fairness with all channels requesting
      for (int t = 0; t < 5; t++) begin
         petition = 4'b1111;
         runTxn(int'($urandom_range(1, 4)), ch);
         check("rr_order", ch, order[t]);
      end

      // single read
      petition = 4'b0001; address[15:0] = 16'h000C;
      runTxn(4, ch);
      check("single_ch", ch, 32'd0);

      // write leaves dataRead unchanged
      petition = 4'b0010; we = 4'b0010; address[AW +: AW] = 16'h0040;
      dataWrite[LW +: LW] = {32{8'hA5}};
      runTxn(3, ch);
      check("write_ch", ch, 32'd1);
      we = 4'b0000;

      // timeout, then a normal request
      petition = 4'b0100;
      runTxn(1000, ch);
      check("tmo_ch", ch, 32'd2);
      petition = 4'b1000;
      runTxn(2, ch);
      check("after_tmo_ch", ch, 32'd3);

      // answer in the last counted cycle: no error
      petition = 4'b0001;
      runTxn(TMO, ch);

      // reset during WAIT
      petition = 4'b0110;
      @(negedge clk);
      check("rstw_pmem", petitionMem, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; petition = 4'b1111;
      check("rstw_drop", {petitionMem, serviceReady, error}, 6'b000000);
      modelLast = NCH - 1; modelData = {LW{1'b0}};
      runTxn(2, ch);
      check("rstw_first", ch, 32'd0);

      // random traffic
      for (int t = 0; t < 40; t++) begin
         petition = NCH'($urandom_range(1, 15));
         we       = NCH'($urandom);
         for (int c = 0; c < NCH; c++) begin
            address[c*AW +: AW]   = AW'($urandom);
            dataWrite[c*LW +: LW] = randLine();
         end
         runTxn(int'($urandom_range(1, TMO + 2)), ch);
         check("rand_ch", ch, modelLast);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
